// File: rtl/mem_store_unit_pkg.sv
// Shared store/load constants: funct3 size encodings and the store FSM states.
package mem_store_unit_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR0  = 2'd1,
        ST_WR1  = 2'd2
    } st_state_e;

    // Byte-size mask for a store; zero marks an illegal funct3.
    function automatic logic [3:0] size_mask(input logic [2:0] funct3);
        case (funct3)
            F3_SB:   return 4'b0001;
            F3_SH:   return 4'b0011;
            F3_SW:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/mem_store_unit_st_align.sv
// Combinational store aligner: spreads LSB-justified data and enables over two words.
module st_align
    import mem_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  off,
    input  logic [31:0] rs2_data,
    output logic [63:0] data64,
    output logic [7:0]  be8,
    output logic        illegal_size
);

    logic [3:0]  mask;
    logic [31:0] byte_mask;

    always_comb begin
        mask         = size_mask(funct3);
        illegal_size = (mask == 4'b0000);
        byte_mask    = {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
        // Masking before the shift keeps disabled lanes at zero.
        data64       = {32'b0, rs2_data & byte_mask} << {off, 3'b000};
        be8          = {4'b0000, mask} << off;
    end

endmodule

// File: rtl/mem_store_unit.sv
// Store unit: aligns SB/SH/SW data and issues one or two word beats over valid/ready.
module mem_store_unit
    import mem_store_unit_pkg::*;
#(
    parameter int MISALIGN_SPLIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] inst,
    input  logic [31:0] addr,
    input  logic [31:0] rs2_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_we,
    output logic        busy,
    output logic        done,
    output logic        fault
);

    // Handshake: a beat transfers on a rising edge where mem_valid && mem_ready;
    // the payload is held unchanged until then and mem_valid only drops after it.
    st_state_e   state;
    logic [31:0] beat1_addr;
    logic [31:0] beat1_wdata;
    logic [3:0]  beat1_we;

    logic [63:0] data64;
    logic [7:0]  be8;
    logic        illegal_size;
    logic        req_illegal;
    logic        unused_inst;

    st_align u_align (
        .funct3       (inst[14:12]),
        .off          (addr[1:0]),
        .rs2_data     (rs2_data),
        .data64       (data64),
        .be8          (be8),
        .illegal_size (illegal_size)
    );

    assign req_illegal = illegal_size || ((MISALIGN_SPLIT == 0) && (be8[7:4] != 4'b0000));
    assign req_ready   = (state == ST_IDLE);
    assign busy        = (state != ST_IDLE);
    assign unused_inst = ^{inst[31:15], inst[11:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            mem_valid   <= 1'b0;
            mem_addr    <= 32'd0;
            mem_wdata   <= 32'd0;
            mem_we      <= 4'd0;
            beat1_addr  <= 32'd0;
            beat1_wdata <= 32'd0;
            beat1_we    <= 4'd0;
            done        <= 1'b0;
            fault       <= 1'b0;
        end else begin
            done  <= 1'b0;
            fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        if (req_illegal) begin
                            fault <= 1'b1;
                        end else begin
                            mem_valid   <= 1'b1;
                            mem_addr    <= {addr[31:2], 2'b00};
                            mem_wdata   <= data64[31:0];
                            mem_we      <= be8[3:0];
                            beat1_addr  <= {addr[31:2], 2'b00} + 32'd4;
                            beat1_wdata <= data64[63:32];
                            beat1_we    <= be8[7:4];
                            state       <= ST_WR0;
                        end
                    end
                end
                ST_WR0: begin
                    if (mem_ready) begin
                        if (beat1_we != 4'b0000) begin
                            mem_addr  <= beat1_addr;
                            mem_wdata <= beat1_wdata;
                            mem_we    <= beat1_we;
                            state     <= ST_WR1;
                        end else begin
                            mem_valid <= 1'b0;
                            done      <= 1'b1;
                            state     <= ST_IDLE;
                        end
                    end
                end
                ST_WR1: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_store_unit.sv
// Bench for mem_store_unit: directed plan steps plus random stores against a byte-level model.
module tb_mem_store_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_valid_b;
    logic [31:0] inst, addr, rs2_data;
    logic        mem_ready;
    logic        mem_ready_b;

    logic        req_ready, mem_valid, busy, done, fault;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_we;

    logic        req_ready_b, mem_valid_b, busy_b, done_b, fault_b;
    logic [31:0] mem_addr_b, mem_wdata_b;
    logic [3:0]  mem_we_b;

    int vectors = 0;
    int miscompares = 0;
    logic [67:0] exp_q[$];

    always #5 clk = ~clk;

    mem_store_unit #(.MISALIGN_SPLIT(1)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .inst(inst), .addr(addr), .rs2_data(rs2_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .busy(busy), .done(done), .fault(fault)
    );

    mem_store_unit #(.MISALIGN_SPLIT(0)) dut_b (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .inst(inst), .addr(addr), .rs2_data(rs2_data),
        .mem_valid(mem_valid_b), .mem_ready(mem_ready_b), .mem_addr(mem_addr_b),
        .mem_wdata(mem_wdata_b), .mem_we(mem_we_b), .busy(busy_b), .done(done_b), .fault(fault_b)
    );

    task automatic check(input string tag, input logic [67:0] obs, input logic [67:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Byte-by-byte model: each stored byte lands at addr+i; bytes in the first word form beat0.
    task automatic model_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                               input bit split, output bit illegal);
        int n;
        logic [31:0] w0, ba, d0, d1;
        logic [3:0]  we0, we1;
        n  = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
        w0 = a & 32'hFFFF_FFFC;
        d0 = '0; d1 = '0; we0 = '0; we1 = '0;
        for (int i = 0; i < n; i++) begin
            ba = a + i;
            if ((ba & 32'hFFFF_FFFC) == w0) begin
                d0[8*ba[1:0] +: 8] = d[8*i +: 8];
                we0[ba[1:0]] = 1'b1;
            end else begin
                d1[8*ba[1:0] +: 8] = d[8*i +: 8];
                we1[ba[1:0]] = 1'b1;
            end
        end
        illegal = (n == 0) || (!split && we1 != 4'b0);
        if (!illegal) begin
            exp_q.push_back({w0, d0, we0});
            if (we1 != 4'b0) exp_q.push_back({w0 + 32'd4, d1, we1});
        end
    endtask

    task automatic drive_req(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        inst     = {$urandom_range(32'h1FFFF, 0) & 32'h1FFFF, 15'd0} | {17'd0, f3, 12'h023};
        addr     = a;
        rs2_data = d;
    endtask

    task automatic run_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                             input int wait_cycles);
        bit illegal;
        model_store(f3, a, d, 1'b1, illegal);
        @(negedge clk);
        check("req_ready_before", {67'd0, req_ready}, 68'd1);
        drive_req(f3, a, d);
        req_valid = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b0;
        addr      = $urandom;
        rs2_data  = $urandom;
        inst      = $urandom;
        if (illegal) begin
            check("fault_pulse", {66'd0, fault, mem_valid}, {66'd0, 2'b10});
            check("idle_after_fault", {67'd0, busy}, 68'd0);
            return;
        end
        while (exp_q.size() > 0) begin
            for (int w = 0; w <= wait_cycles; w++) begin
                check("beat_payload", {mem_addr, mem_wdata, mem_we}, exp_q[0]);
                check("beat_ctl", {65'd0, mem_valid, busy, done}, {65'd0, 3'b110});
                mem_ready = (w == wait_cycles);
                @(negedge clk);
            end
            mem_ready = 1'b0;
            void'(exp_q.pop_front());
        end
        check("done_pulse", {65'd0, done, req_ready, mem_valid}, {65'd0, 3'b110});
    endtask

    task automatic run_store_b(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        bit illegal;
        model_store(f3, a, d, 1'b0, illegal);
        @(negedge clk);
        drive_req(f3, a, d);
        req_valid_b = 1'b1;
        @(negedge clk);
        req_valid_b = 1'b0;
        if (illegal) begin
            check("b_fault", {66'd0, fault_b, mem_valid_b}, {66'd0, 2'b10});
            @(negedge clk);
            check("b_fault_clear", {66'd0, fault_b, mem_valid_b}, 68'd0);
        end else begin
            check("b_beat", {mem_addr_b, mem_wdata_b, mem_we_b}, exp_q[0]);
            check("b_valid", {67'd0, mem_valid_b}, 68'd1);
            void'(exp_q.pop_front());
            @(negedge clk);
            check("b_done", {66'd0, done_b, mem_valid_b}, {66'd0, 2'b10});
        end
    endtask

    initial begin
        reset = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0;
        mem_ready = 1'b0; mem_ready_b = 1'b1;
        inst = '0; addr = '0; rs2_data = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {mem_addr, mem_wdata, mem_we},  68'd0);
        check("reset_ctl", {62'd0, mem_valid, done, fault, busy, req_ready, 1'b0}, {62'd0, 6'b000010});
        reset = 1'b0;

        // Directed plan steps; explicit expected beats cross-check the model.
        run_store(3'b010, 32'h0000_1000, 32'hAABB_CCDD, 0);
        run_store(3'b000, 32'h0000_2002, 32'h1234_56EF, 0);
        run_store(3'b010, 32'h0000_1003, 32'hAABB_CCDD, 0);
        run_store(3'b010, 32'h0000_1003, 32'hAABB_CCDD, 3);
        run_store(3'b011, 32'h0000_1000, 32'h1111_2222, 0);
        run_store(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF, 1);
        run_store_b(3'b001, 32'h0000_3003, 32'h0000_5A5A);
        run_store_b(3'b001, 32'h0000_3001, 32'h0000_5A5A);

        // Explicit wrap check independent of the model.
        @(negedge clk);
        drive_req(3'b001, 32'hFFFF_FFFF, 32'h0000_BEEF);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("wrap_beat0", {mem_addr, mem_wdata, mem_we}, {32'hFFFF_FFFC, 32'hEF00_0000, 4'b1000});
        mem_ready = 1'b1;
        @(negedge clk);
        check("wrap_beat1", {mem_addr, mem_wdata, mem_we}, {32'h0000_0000, 32'h0000_00BE, 4'b0001});
        @(negedge clk);
        mem_ready = 1'b0;
        check("wrap_done", {67'd0, done}, 68'd1);

        // Reset while beat1 is stalled.
        @(negedge clk);
        drive_req(3'b010, 32'h0000_1003, 32'hAABB_CCDD);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check("stall_in_wr1", {mem_addr, mem_wdata, mem_we}, {32'h0000_1004, 32'h00AA_BBCC, 4'b0111});
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst_mid_payload", {mem_addr, mem_wdata, mem_we}, 68'd0);
        check("rst_mid_ctl", {63'd0, mem_valid, done, fault, busy, req_ready}, {63'd0, 5'b00001});
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("no_done_after_rst", {66'd0, done, mem_valid}, 68'd0);

        // Random stores; funct3 sometimes illegal.
        for (int k = 0; k < 150; k++) begin
            run_store($urandom_range(4, 0), $urandom, $urandom, $urandom_range(2, 0));
        end
        for (int k = 0; k < 40; k++) begin
            run_store_b($urandom_range(2, 0), $urandom, $urandom);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_store_unit.md
# mem_store_unit

Store-side memory access unit for the RISC-V core. Sits between execute and the data memory/MMIO port, the write-direction counterpart of the load-extend/writeback path. Takes an SB/SH/SW request (ALU address + rs2 data), aligns the data onto byte lanes, and generates byte write enables. Issues one or two word-aligned write beats over a valid/ready handshake, stalling the pipeline until the store commits.

## Interface
Parameters:
- MISALIGN_SPLIT, default 1: 1 = misaligned stores split into two beats; 0 = misaligned stores raise `fault` and write nothing.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  execute stage presents a store.
- req_ready  out  1  unit can accept a request; high iff state is IDLE.
- inst  in  32  store instruction; funct3 = inst[14:12] (000 SB, 001 SH, 010 SW, others illegal).
- addr  in  32  byte address (ALU result).
- rs2_data  in  32  store data, LSB-justified.
- mem_valid  out  1  write beat valid.
- mem_ready  in  1  memory accepts beat when high with mem_valid.
- mem_addr  out  32  word address, bits [1:0] always 0.
- mem_wdata  out  32  lane-aligned data; lanes with mem_we=0 driven 0.
- mem_we  out  4  byte enables, bit i = byte lane i.
- busy  out  1  pipeline stall; high iff state is not IDLE.
- done  out  1  one-cycle pulse, store fully committed.
- fault  out  1  one-cycle pulse, illegal funct3 or misaligned with MISALIGN_SPLIT=0.

## Operation
- Alignment: off = addr[1:0]; size mask = 0001/0011/1111 for SB/SH/SW.
  - 64-bit lane vector: data64 = rs2_data << 8*off; 8-bit enable: be8 = mask << off.
  - Beat0 = {data64[31:0], be8[3:0]} at {addr[31:2],2'b00}.
  - Beat1 = {data64[63:32], be8[7:4]} at beat0 address + 4, wrapping mod 2^32.
- FSM states: IDLE, WR0, WR1.
  - IDLE, req_valid=1, legal request: register beats, go to WR0.
  - IDLE, illegal request (funct3, or be8[7:4]≠0 with MISALIGN_SPLIT=0): pulse fault next cycle, stay IDLE, no memory access.
  - WR0: drive beat0. On mem_ready, go to WR1 if beat1 enables ≠0; otherwise go to IDLE and pulse done.
  - WR1: drive beat1. On mem_ready, go to IDLE and pulse done.
- Beat payload (mem_addr/wdata/we) is registered and held stable while mem_valid && !mem_ready.
- Request inputs are sampled only at the accept edge; later changes are ignored.

## Timing
- All outputs except req_ready and busy are registered; req_ready and busy decode directly from state.
- Request accepted at edge N: mem_valid=1 from cycle N+1.
- Final beat handshake at edge M: done=1 and state=IDLE in cycle M+1, so a new request can be accepted in that same cycle.
- Best case: aligned store has 2-cycle issue-to-issue; split store has 3.
- Reset values: state IDLE, mem_valid 0, mem_addr 0, mem_wdata 0, mem_we 0, done 0, fault 0, busy 0, req_ready 1.
- Reset asserted mid-transaction:
  - Immediate return to IDLE with mem_valid dropped.
  - An already-accepted beat0 is not undone; no done pulse.
- done and fault never assert in the same cycle.
- mem_valid never drops without a handshake, except on reset.

## Structure
- Shared package: funct3 constants (SB/SH/SW) and the FSM state encoding; the load-extend logic uses the same funct3 constants.
- One combinational sub-module `st_align`: (funct3, off, rs2_data) → (data64, be8, illegal_size).
- The FSM and beat registers live in the top module.

## Test plan
- Aligned SW: addr 0x1000, data 0xAABBCCDD, mem_ready=1.
  → one beat {0x1000, 0xAABBCCDD, we 1111}; done 2 cycles after accept.
- SB, off 2: addr 0x2002, data 0x123456EF.
  → {0x2000, 0x00EF0000, we 0100}.
- Misaligned SW, MISALIGN_SPLIT=1: addr 0x1003, data 0xAABBCCDD.
  → beat0 {0x1000, 0xDD000000, we 1000}, then beat1 {0x1004, 0x00AABBCC, we 0111}.
- Wait states: same split store, mem_ready held low 3 cycles per beat.
  → payload stable throughout, busy=1, done once.
- Illegal funct3 011, and SH at off 3 with MISALIGN_SPLIT=0.
  → fault pulse, mem_valid stays 0.
- Reset asserted while WR1 is stalled.
  → mem_valid=0 immediately, all outputs at reset values, no done.
- Address wrap: SH to 0xFFFFFFFF, data 0xBEEF.
  → beat0 {0xFFFFFFFC, 0xEF000000, we 1000}, then beat1 {0x00000000, 0x000000BE, we 0001}.
